// File: rtl/alu_result_stage.sv
// Registered result/flag stage after the add/sub/slt datapath, with a 2-entry skid buffer and debug counters.
// Latency: 1 cycle from accept into an empty stage to out_valid.
// Backpressure: in_ready = !skid_valid (registered only); out_* held stable while out_valid && !out_ready.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_sub,
  input  logic             in_slt,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t           in_ent;
  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d, ovf_count_q, ovf_count_d;
  logic             accept, deliver;

  assign in_ready   = ~skid_vld_q;
  assign out_valid  = main_vld_q;
  assign out_result = main_q.result;
  assign out_zero   = main_q.zero;
  assign out_neg    = main_q.neg;
  assign out_carry  = main_q.carry;
  assign out_ovf    = main_q.ovf;
  assign txn_count  = txn_count_q;
  assign ovf_count  = ovf_count_q;

  assign accept  = in_valid & in_ready;
  assign deliver = main_vld_q & out_ready;

  // Flags derived at the input so they travel with the entry; slt results never overflow.
  always_comb begin
    in_ent        = '0;
    in_ent.result = in_result;
    in_ent.zero   = (in_result == '0);
    in_ent.neg    = in_result[WIDTH-1];
    in_ent.carry  = in_carry;
    if (in_slt) begin
      in_ent.ovf = 1'b0;
    end else if (in_sub) begin
      in_ent.ovf = (in_a_msb != in_b_msb) && (in_result[WIDTH-1] != in_a_msb);
    end else begin
      in_ent.ovf = (in_a_msb == in_b_msb) && (in_result[WIDTH-1] != in_a_msb);
    end
  end

  // Main/skid next state: skid drains into main first, otherwise new entries fill the first free slot.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (deliver) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = in_ent;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
  end

  // Debug counters: clear has priority; txn wraps, ovf saturates.
  always_comb begin
    txn_count_d = txn_count_q;
    ovf_count_d = ovf_count_q;
    if (cnt_clr) begin
      txn_count_d = '0;
      ovf_count_d = '0;
    end else if (deliver) begin
      txn_count_d = txn_count_q + CNT_ONE;
      if (main_q.ovf && !(&ovf_count_q)) begin
        ovf_count_d = ovf_count_q + CNT_ONE;
      end
    end
  end

  // State registers; reset drops both entries and zeroes all visible data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      txn_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      txn_count_q <= txn_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, skid ordering, streaming, counters, reset.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_carry, in_sub, in_slt, in_a_msb, in_b_msb;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_neg, out_carry, out_ovf;
  logic        cnt_clr;
  logic [15:0] txn_count, ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_sub(in_sub), .in_slt(in_slt),
    .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf),
    .cnt_clr(cnt_clr), .txn_count(txn_count), .ovf_count(ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] res, input logic sub, input logic slt,
                       input logic a, input logic b, input logic cy);
    in_valid  = 1'b1;
    in_result = res;
    in_sub    = sub;
    in_slt    = slt;
    in_a_msb  = a;
    in_b_msb  = b;
    in_carry  = cy;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_result = '0; in_carry = 1'b0; in_sub = 1'b0; in_slt = 1'b0;
    in_a_msb = 1'b0; in_b_msb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", out_result, 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;

    // Single add
    @(negedge clk); drive(32'h5, 0, 0, 0, 0, 0); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'h5);
    chk("add_zero", 32'(out_zero), 32'd0);
    chk("add_neg", 32'(out_neg), 32'd0);
    chk("add_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    chk("add_txn", 32'(txn_count), 32'd1);
    chk("add_drained", 32'(out_valid), 32'd0);

    // Add overflow 0x7FFFFFFF + 1
    drive(32'h8000_0000, 0, 0, 0, 0, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("addovf_ovf", 32'(out_ovf), 32'd1);
    chk("addovf_neg", 32'(out_neg), 32'd1);
    @(negedge clk);
    chk("addovf_cnt", 32'(ovf_count), 32'd1);

    // Sub overflow 0x80000000 - 1 (carry set: no borrow)
    drive(32'h7FFF_FFFF, 1, 0, 1, 0, 1);
    @(negedge clk); in_valid = 1'b0;
    chk("subovf_ovf", 32'(out_ovf), 32'd1);
    chk("subovf_neg", 32'(out_neg), 32'd0);
    chk("subovf_carry", 32'(out_carry), 32'd1);
    @(negedge clk);
    chk("subovf_cnt", 32'(ovf_count), 32'd2);

    // slt: the sub overflow condition holds but must be masked
    drive(32'h1, 1, 1, 1, 0, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("slt_ovf", 32'(out_ovf), 32'd0);
    chk("slt_zero", 32'(out_zero), 32'd0);
    chk("slt_neg", 32'(out_neg), 32'd0);
    chk("slt_result", out_result, 32'h1);
    @(negedge clk);
    chk("slt_txn", 32'(txn_count), 32'd4);

    // Backpressure fills main and skid, third entry held upstream
    out_ready = 1'b0;
    drive(32'h1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(32'h2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_main", out_result, 32'h1);
    drive(32'h3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_stable", out_result, 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out2", out_result, 32'h2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_out3", out_result, 32'h3);
    chk("bp_valid3", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_txn", 32'(txn_count), 32'd7);

    // Clear, then stream 0..7 at full rate
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    chk("clr_txn", 32'(txn_count), 32'd0);
    chk("clr_ovf", 32'(ovf_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(32'(i), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_result, 32'(i));
      if (i == 0) chk("stream_zero", 32'(out_zero), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_txn", 32'(txn_count), 32'd8);

    // Clear coinciding with an overflowing delivery
    drive(32'h8000_0000, 0, 0, 0, 0, 0);
    @(negedge clk); in_valid = 1'b0; cnt_clr = 1'b1;
    chk("clrdel_valid", 32'(out_valid), 32'd1);
    @(negedge clk); cnt_clr = 1'b0;
    chk("clrdel_txn", 32'(txn_count), 32'd0);
    chk("clrdel_ovf", 32'(ovf_count), 32'd0);

    // Saturation: 65537 overflowing deliveries -> ovf saturates, txn wraps to 1
    drive(32'h8000_0000, 0, 0, 0, 0, 0);
    repeat (65537) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_ovf", 32'(ovf_count), 32'h0000_FFFF);
    chk("wrap_txn", 32'(txn_count), 32'd1);

    // Reset with both entries full
    out_ready = 1'b0;
    drive(32'hA, 0, 0, 0, 0, 0);
    @(negedge clk); drive(32'hB, 0, 0, 0, 0, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_result", out_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
